// File: rtl/clk_flag_pkg.sv
// Shared definitions for the clock-enable flag checker: state encoding and
// a saturating add used by every counter in the block.
package clk_flag_pkg;

  typedef enum logic [1:0] {
    E_IDLE    = 2'd0,
    E_MEASURE = 2'd1,
    E_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = E_IDLE;
  localparam logic [ST_W-1:0] ST_MEASURE = E_MEASURE;
  localparam logic [ST_W-1:0] ST_LOCKED  = E_LOCKED;

  // a + b clamped to lim; callers cast the result down to their own width
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/clk_flag_checker_if.sv
// Flag strobe plus measurement/status bundle between a strobe source (master)
// and the checker (slave).
interface clk_flag_checker_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
);

  logic             clk_flag;
  logic [CNT_W-1:0] period_meas;
  logic             period_vld;
  logic             locked;
  logic             err_period;
  logic             err_width;
  logic             err_timeout;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clk_flag,
    input  period_meas, period_vld, locked,
    input  err_period, err_width, err_timeout, err_cnt
  );

  modport slave (
    input  clk_flag,
    output period_meas, period_vld, locked,
    output err_period, err_width, err_timeout, err_cnt
  );

endinterface

// File: rtl/flag_edge_det.sv
// Rising-edge and over-wide-pulse detector for a single-cycle strobe.
// Both outputs are combinational from i_flag; consumers register them.
module flag_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flag,
  output logic o_edge_c,
  output logic o_width_err_c
);

  logic r_flag_d;
  logic r_flag_dd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_d  <= 1'b0;
      r_flag_dd <= 1'b0;
    end else begin
      r_flag_d  <= i_flag;
      r_flag_dd <= r_flag_d;
    end
  end

  assign o_edge_c      = i_flag & ~r_flag_d;
  // fires only on the second high cycle, so one report per over-wide pulse
  assign o_width_err_c = i_flag & r_flag_d & ~r_flag_dd;

endmodule

// File: rtl/clk_flag_checker.sv
// Period/width/timeout checker for a clock-enable strobe in the sys_clk domain.
// Declares lock after LOCK_CNT consecutive on-period intervals.
module clk_flag_checker
  import clk_flag_pkg::*;
#(
  parameter int unsigned PERIOD   = 5,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ERR_W    = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  clk_flag_checker_if.slave  bus
);

  localparam int unsigned      MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PER_VAL   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(2 * PERIOD);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

  logic w_edge;
  logic w_width_err;

  flag_edge_det u_edge_det (
    .clk           (sys_clk),
    .rst_n         (sys_rst_n),
    .i_flag        (bus.clk_flag),
    .o_edge_c      (w_edge),
    .o_width_err_c (w_width_err)
  );

  logic [ST_W-1:0]    r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_gap, w_gap_nxt;
  logic [MATCH_W-1:0] r_match, w_match_nxt;
  logic [CNT_W-1:0]   r_period_meas, w_meas_nxt;
  logic               r_period_vld, w_vld_nxt;
  logic               r_locked, w_locked_nxt;
  logic               r_err_period, w_eper_nxt;
  logic               r_err_width, w_ewid_nxt;
  logic               r_err_timeout, w_etmo_nxt;
  logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nxt;

  logic [CNT_W-1:0]   w_interval;
  logic [MATCH_W-1:0] w_match_inc;

  // interval = gap+1, saturating; also the non-edge next value of gap
  assign w_interval  = CNT_W'(sat_add(32'(r_gap), 32'd1, 32'(CNT_MAX)));
  assign w_match_inc = MATCH_W'(sat_add(32'(r_match), 32'd1, 32'(LOCK_CNT)));

  // next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match;
    w_locked_nxt = r_locked;
    w_meas_nxt   = r_period_meas;
    w_vld_nxt    = 1'b0;
    w_eper_nxt   = 1'b0;
    w_etmo_nxt   = 1'b0;
    w_ewid_nxt   = w_width_err;
    w_gap_nxt    = w_edge ? '0 : w_interval;

    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE, ST_LOCKED: begin
        if (w_edge) begin
          w_meas_nxt = w_interval;
          w_vld_nxt  = 1'b1;
          if (w_interval == PER_VAL) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MATCH_MAX) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_eper_nxt   = 1'b1;
            w_match_nxt  = '0;
            w_locked_nxt = 1'b0;
            w_state_nxt  = ST_MEASURE;
          end
        end else if (w_interval == TMO_VAL) begin
          // leaving for IDLE disarms the timeout until the next edge
          w_etmo_nxt   = 1'b1;
          w_match_nxt  = '0;
          w_locked_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_match_nxt  = '0;
        w_locked_nxt = 1'b0;
      end
    endcase

    w_err_cnt_nxt = ERR_W'(sat_add(32'(r_err_cnt),
                                   32'(w_eper_nxt) + 32'(w_ewid_nxt) + 32'(w_etmo_nxt),
                                   32'(ERR_MAX)));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_gap         <= '0;
      r_match       <= '0;
      r_period_meas <= '0;
      r_period_vld  <= 1'b0;
      r_locked      <= 1'b0;
      r_err_period  <= 1'b0;
      r_err_width   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gap         <= w_gap_nxt;
      r_match       <= w_match_nxt;
      r_period_meas <= w_meas_nxt;
      r_period_vld  <= w_vld_nxt;
      r_locked      <= w_locked_nxt;
      r_err_period  <= w_eper_nxt;
      r_err_width   <= w_ewid_nxt;
      r_err_timeout <= w_etmo_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign bus.period_meas = r_period_meas;
  assign bus.period_vld  = r_period_vld;
  assign bus.locked      = r_locked;
  assign bus.err_period  = r_err_period;
  assign bus.err_width   = r_err_width;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_clk_flag_checker.sv
// Directed bench for clk_flag_checker with PERIOD=5, LOCK_CNT=3, ERR_W=8.
module tb_clk_flag_checker;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;
  int n_vld = 0;
  int n_ep  = 0;
  int n_ew  = 0;
  int n_et  = 0;

  clk_flag_checker_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  clk_flag_checker #(
    .PERIOD   (5),
    .LOCK_CNT (3),
    .CNT_W    (CNT_W),
    .ERR_W    (ERR_W)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of clk_flag, then sample 1 ns after the edge
  task automatic step(input logic f);
    bus.clk_flag = f;
    @(posedge clk);
    #1;
    if (bus.period_vld)  n_vld++;
    if (bus.err_period)  n_ep++;
    if (bus.err_width)   n_ew++;
    if (bus.err_timeout) n_et++;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.clk_flag = 1'b0;
    #12;
    chkn("rst_meas",    32'(bus.period_meas), 32'd0);
    chk1("rst_vld",     bus.period_vld,  1'b0);
    chk1("rst_locked",  bus.locked,      1'b0);
    chk1("rst_eper",    bus.err_period,  1'b0);
    chk1("rst_ewid",    bus.err_width,   1'b0);
    chk1("rst_etmo",    bus.err_timeout, 1'b0);
    chkn("rst_errcnt",  32'(bus.err_cnt), 32'd0);
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: six clean 5-cycle strobes, lock after the 4th
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk1("t1_vld", bus.period_vld, (i > 0));
      if (i > 0) chkn("t1_meas", 32'(bus.period_meas), 32'd5);
      chk1("t1_locked", bus.locked, (i >= 3));
      step(1'b0);
      chk1("t1_vld_clr", bus.period_vld, 1'b0);
      repeat (3) step(1'b0);
    end
    chkn("t1_nvld",   32'(n_vld), 32'd5);
    chkn("t1_nerr",   32'(n_ep + n_ew + n_et), 32'd0);
    chkn("t1_errcnt", 32'(bus.err_cnt), 32'd0);

    // 2: one interval of 7, then relock over three good periods
    repeat (2) step(1'b0);
    step(1'b1);
    chk1("t2_vld",    bus.period_vld, 1'b1);
    chkn("t2_meas",   32'(bus.period_meas), 32'd7);
    chk1("t2_eper",   bus.err_period, 1'b1);
    chk1("t2_locked", bus.locked, 1'b0);
    chkn("t2_errcnt", 32'(bus.err_cnt), 32'd1);
    for (int j = 0; j < 3; j++) begin
      repeat (4) step(1'b0);
      step(1'b1);
      chkn("t2_relock_meas", 32'(bus.period_meas), 32'd5);
      chk1("t2_relock", bus.locked, (j == 2));
    end

    // 3: on-time strobe held high for three cycles
    repeat (4) step(1'b0);
    n_ew = 0;
    step(1'b1);
    chk1("t3_locked_a", bus.locked, 1'b1);
    step(1'b1);
    chk1("t3_ewid",     bus.err_width, 1'b1);
    chk1("t3_locked_b", bus.locked, 1'b1);
    step(1'b1);
    chk1("t3_ewid_clr", bus.err_width, 1'b0);
    repeat (2) step(1'b0);
    step(1'b1);
    chk1("t3_vld",      bus.period_vld, 1'b1);
    chkn("t3_meas",     32'(bus.period_meas), 32'd5);
    chk1("t3_eper",     bus.err_period, 1'b0);
    chk1("t3_locked_c", bus.locked, 1'b1);
    chkn("t3_new",      32'(n_ew), 32'd1);
    chkn("t3_errcnt",   32'(bus.err_cnt), 32'd2);

    // 4: stuck low -> single timeout 10 cycles after the last edge
    n_et = 0;
    repeat (9) step(1'b0);
    chk1("t4_etmo_early", bus.err_timeout, 1'b0);
    chk1("t4_locked_a",   bus.locked, 1'b1);
    step(1'b0);
    chk1("t4_etmo",     bus.err_timeout, 1'b1);
    chk1("t4_locked_b", bus.locked, 1'b0);
    chkn("t4_errcnt",   32'(bus.err_cnt), 32'd3);
    repeat (20) step(1'b0);
    chkn("t4_net", 32'(n_et), 32'd1);
    step(1'b1);
    chk1("t4_arm_vld", bus.period_vld, 1'b0);
    repeat (4) step(1'b0);
    step(1'b1);
    chk1("t4_vld",  bus.period_vld, 1'b1);
    chkn("t4_meas", 32'(bus.period_meas), 32'd5);
    // edge landing exactly on the timeout cycle is measured, not timed out
    repeat (9) step(1'b0);
    step(1'b1);
    chk1("t4b_eper",   bus.err_period, 1'b1);
    chk1("t4b_etmo",   bus.err_timeout, 1'b0);
    chkn("t4b_meas",   32'(bus.period_meas), 32'd10);
    chkn("t4b_errcnt", 32'(bus.err_cnt), 32'd4);
    chkn("t4b_net",    32'(n_et), 32'd1);

    // 5: asynchronous reset while locked
    for (int k = 0; k < 3; k++) begin
      repeat (4) step(1'b0);
      step(1'b1);
    end
    chk1("t5_locked", bus.locked, 1'b1);
    chk1("t5_vld_pre", bus.period_vld, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_locked", bus.locked, 1'b0);
    chk1("t5_rst_vld",    bus.period_vld, 1'b0);
    chkn("t5_rst_meas",   32'(bus.period_meas), 32'd0);
    chkn("t5_rst_errcnt", 32'(bus.err_cnt), 32'd0);
    repeat (2) step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b1);
    chk1("t5_arm_vld", bus.period_vld, 1'b0);
    repeat (4) step(1'b0);
    step(1'b1);
    chk1("t5_vld",     bus.period_vld, 1'b1);
    chkn("t5_meas",    32'(bus.period_meas), 32'd5);
    chk1("t5_locked2", bus.locked, 1'b0);

    // 6: 300 interval-of-4 errors saturate err_cnt at 255
    n_ep = 0;
    for (int i = 1; i <= 300; i++) begin
      repeat (3) step(1'b0);
      step(1'b1);
      if (i == 254) chkn("t6_cnt254", 32'(bus.err_cnt), 32'd254);
      if (i == 255) chkn("t6_cnt255", 32'(bus.err_cnt), 32'd255);
    end
    chkn("t6_sat",  32'(bus.err_cnt), 32'd255);
    chkn("t6_nep",  32'(n_ep), 32'd300);
    chkn("t6_meas", 32'(bus.period_meas), 32'd4);
    chk1("t6_eper", bus.err_period, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
